pipe_reg_elastic: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH data stages, each WIDTH bits with its own valid bit, moved by a valid/ready handshake with per-stage back-pressure and a synchronous flush. It replaces bare `FlipFlop` chains between multi-cycle core datapath sections wherever a producer and consumer must stall independently or squash in-flight work.

---
 rtl/pipe_reg_elastic.sv | 127 ++++++++++++
 tb/tb_pipe_reg_elastic.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/ready stages with collapsing bubbles and synchronous flush.
// Optional one-entry input skid buffer enabled by defining PIPE_REG_SKID_EN.
module pipe_reg_elastic #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 2);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic [OccW-1:0]  occ_q, occ_d;

`ifdef PIPE_REG_SKID_EN
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic             accept;
`endif

  // A stage can load when it is empty or everything downstream of it can move.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = !v_q[i] | rdy[i+1];
    end
  end

`ifdef PIPE_REG_SKID_EN
  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  always_comb begin
    in_ready = !skid_v_q & !flush;
    accept   = in_valid & !skid_v_q;
    src_v    = skid_v_q | accept;
    src_d    = skid_v_q ? skid_d_q : in_data;
    skid_v_d = skid_v_q ? !rdy[0] : (accept & !rdy[0]);
    skid_d_d = (accept & !rdy[0]) ? in_data : skid_d_q;
    if (flush) begin
      skid_v_d = 1'b0;
    end
  end
`else
  always_comb begin
    in_ready = rdy[0] & !flush;
    src_v    = in_valid;
    src_d    = in_data;
  end
`endif

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = src_v;
      if (src_v) begin
        d_d[0] = src_d;
      end
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
    // Flush squashes valids only; data registers keep their contents.
    if (flush) begin
      v_d = '0;
      d_d = d_q;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OccW'(v_d[i]);
    end
`ifdef PIPE_REG_SKID_EN
    occ_d = occ_d + OccW'(skid_v_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= '0;
      end
`ifdef PIPE_REG_SKID_EN
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
`endif
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= d_d[i];
      end
`ifdef PIPE_REG_SKID_EN
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
`endif
    end
  end

  assign out_valid = v_q[DEPTH-1] & !flush;
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic (DEPTH=2): per-cycle vector table plus hand sequences,
// with a data scoreboard checking order/loss/duplication. Honours PIPE_REG_SKID_EN if defined.
module tb_pipe_reg_elastic;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
`ifdef PIPE_REG_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       occupancy;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic             ordy;
    logic [WIDTH-1:0] din;
    logic             eir;
    logic             eov;
    logic [WIDTH-1:0] eod;
    logic [1:0]       eocc;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] sb[$];
  int               checks = 0;
  int               errors = 0;
  logic             s_ir, s_ov;
  logic [WIDTH-1:0] s_od;
  logic [1:0]       s_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, account transfers, advance past posedge.
  task automatic tick(input logic iv, input logic ordy, input logic fl, input logic [WIDTH-1:0] din);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = din;
    @(negedge clk);
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_od  = out_data;
    s_occ = occupancy;
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h required no output", out_data);
        end else begin
          chk("sb_order", out_data, sb.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic ordy, input logic [WIDTH-1:0] din,
                     input logic eir, input logic eov, input logic [WIDTH-1:0] eod,
                     input logic [1:0] eocc);
    vecs.push_back('{iv: iv, ordy: ordy, din: din, eir: eir, eov: eov, eod: eod, eocc: eocc});
  endtask

  initial begin
    // Streaming, 1..10 back to back; output appears two cycles after accept.
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 2, 1, 0, 0, 1);
    for (int c = 2; c < 10; c++) add(1, 1, WIDTH'(c + 1), 1, 1, WIDTH'(c - 1), 2);
    add(0, 1, 0, 1, 1, 9, 2);
    add(0, 1, 0, 1, 1, 10, 1);
    add(0, 1, 0, 1, 0, 0, 0);
    // Back-pressure fill with 5 offered beats, then release.
    add(1, 0, 'h21, 1, 0, 0, 0);
    add(1, 0, 'h22, 1, 0, 0, 1);
    add(1, 0, 'h23, Skid, 1, 'h21, 2);
    add(1, 0, 'h24, 0, 1, 'h21, Skid ? 2'd3 : 2'd2);
    add(1, 0, 'h25, 0, 1, 'h21, Skid ? 2'd3 : 2'd2);
    add(0, 1, 0, !Skid, 1, 'h21, Skid ? 2'd3 : 2'd2);
    add(0, 1, 0, 1, 1, 'h22, Skid ? 2'd2 : 2'd1);
    add(0, 1, 0, 1, Skid, Skid ? 'h23 : 0, Skid ? 2'd1 : 2'd0);
    add(0, 1, 0, 1, 0, 0, 0);

    // Reset for 2 cycles with in_valid high, then first post-reset cycle.
    reset = 1'b1;
    tick(1, 0, 0, 'hdead);
    tick(1, 0, 0, 'hdead);
    reset = 1'b0;
    tick(0, 0, 0, 0);
    chk("rst_in_ready", 32'(s_ir), 1);
    chk("rst_out_valid", 32'(s_ov), 0);
    chk("rst_out_data", s_od, 0);
    chk("rst_occupancy", 32'(s_occ), 0);

    foreach (vecs[i]) begin
      tick(vecs[i].iv, vecs[i].ordy, 1'b0, vecs[i].din);
      chk($sformatf("vec%0d_in_ready", i), 32'(s_ir), 32'(vecs[i].eir));
      chk($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(vecs[i].eov));
      chk($sformatf("vec%0d_occupancy", i), 32'(s_occ), 32'(vecs[i].eocc));
      if (vecs[i].eov) chk($sformatf("vec%0d_out_data", i), s_od, vecs[i].eod);
    end

    // Full pipeline with simultaneous in and out for 4 cycles.
    tick(1, 0, 0, 'h31);
    tick(1, 0, 0, 'h32);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, WIDTH'('h33 + i));
      chk("full_occupancy", 32'(s_occ), 2);
      chk("full_in_ready", 32'(s_ir), 1);
      chk("full_out_valid", 32'(s_ov), 1);
    end
    tick(0, 1, 0, 0);
    chk("full_after_occupancy", 32'(s_occ), 2);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    chk("full_drained", 32'(sb.size()), 0);

    // Flush with two beats held; the flush-cycle beat must never emerge.
    tick(1, 0, 0, 'h41);
    tick(1, 0, 0, 'h42);
    tick(1, 1, 1, 'hbad);
    chk("flush_in_ready", 32'(s_ir), 0);
    chk("flush_out_valid", 32'(s_ov), 0);
    sb.delete();
    tick(0, 1, 0, 0);
    chk("flush_occupancy", 32'(s_occ), 0);
    chk("flush_after_out_valid", 32'(s_ov), 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
